id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register sitting directly downstream of the register file.
- Drives the regfile read addresses from the decoded instruction and captures the read data.
- Patches the write-back-to-read hazard: the register file writes on the clock edge but reads combinationally, so a same-cycle read would return the stale value.
- Holds the instruction under a valid/ready handshake and keeps held operands coherent with write-backs during stalls.

Parameters:
- XLEN, 32, data/PC/immediate width
- CTRL_W, 16, width of the opaque decoded-control bundle carried through unchanged

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1  in  5  source register 1 index
- in_rs2  in  5  source register 2 index
- in_rd  in  5  destination index
- in_imm  in  XLEN  decoded immediate
- in_ctrl  in  CTRL_W  decoded control bundle
- rf_rs1  out  5  regfile read address 1 (combinational copy of in_rs1)
- rf_rs2  out  5  regfile read address 2 (combinational copy of in_rs2)
- rf_rdata1  in  XLEN  regfile read data 1
- rf_rdata2  in  XLEN  regfile read data 2
- wb_we  in  1  write-back enable (same signal driving the regfile write)
- wb_rd  in  5  write-back destination
- wb_wdata  in  XLEN  write-back data
- flush  in  1  squash held and incoming instruction (branch redirect)
- out_valid  out  1  execute-side instruction valid
- out_ready  in  1  execute accepts this cycle
- out_pc  out  XLEN  registered PC
- out_rs1, out_rs2  out  5 each  registered source indices (for EX forwarding)
- out_rd  out  5  registered destination
- out_op1, out_op2  out  XLEN each  registered operand values
- out_imm  out  XLEN  registered immediate
- out_ctrl  out  CTRL_W  registered control bundle

Behaviour:
- Reset (async, rst=1): out_valid=0; every other registered output is 0. in_ready=1 after reset.
- in_ready = !out_valid || out_ready (combinational). It does not depend on in_valid.
- Capture condition: cap = in_valid && in_ready && !flush.
  - On cap, at the next edge all out_* load from the inputs and out_valid=1.
- Drain: out_valid && out_ready && !cap → out_valid=0 at the next edge; data registers hold.
- Flush priority: flush=1 → out_valid=0 at the next edge regardless of in_valid or out_ready. No capture; data registers may hold.
- Operand select at capture, for each n in {1,2}:
  - in_rsn==0 → 0.
  - else wb_we && wb_rd==in_rsn → wb_wdata.
  - else rf_rdatan.
  - wb_rd==0 never bypasses.
- Stall refresh: when out_valid && !out_ready && !flush, for each operand:
  - if wb_we && wb_rd!=0 && wb_rd==out_rsn, then out_opn <= wb_wdata.
  - Both operands update when out_rs1==out_rs2.
- Capture and refresh are mutually exclusive; capture requires in_ready, which excludes a stalled hold.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 instruction per cycle while out_ready=1.
- out_pc, out_imm, out_ctrl, out_rd, out_rs1 and out_rs2 pass unmodified; no arithmetic.
- The execute stage samples out_* only when out_valid=1; contents are don't-care otherwise.
- rst asserted mid-stall: out_valid drops immediately (async) and the instruction is lost. Upstream refetches.

Test Plan:
- Reset: assert rst mid-transfer → out_valid=0 and out_op1=0 immediately, without waiting for a clock edge. After release, in_ready=1.
- Plain pass-through: regfile x5=0x11, x6=0x22; send rs1=5, rs2=6, rd=7, imm=0x4, pc=0x100 with out_ready=1 → next cycle out_valid=1, op1=0x11, op2=0x22, pc=0x100, rd=7.
- WB bypass: same cycle wb_we=1, wb_rd=5, wb_wdata=0xABCD while rf_rdata1 still returns 0x11 → out_op1=0xABCD. Repeat with wb_rd=0 → op1 from regfile. Repeat with rs1=0 → op1=0.
- Stall refresh: hold with out_ready=0 for 3 cycles, out_rs2=6; in cycle 2 WB writes x6=0x99 → out_op2=0x99 from the next cycle. in_ready=0 throughout and out_pc unchanged.
- Flush: out_valid=1, out_ready=0, in_valid=1, flush=1 → next cycle out_valid=0 and the incoming instruction is not captured. The following cycle accepts new input.
- Back-to-back stream: 8 instructions with out_ready toggling 1,0,1,1,0,… → each instruction appears exactly once, in order, with no drops or duplicates. Throughput is 1 per cycle whenever out_ready=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: drives regfile read addresses, captures
// operands with write-back bypass, and keeps held operands current during stalls.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        rf_rs1,
  output logic [4:0]        rf_rs2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_wdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic            cap;
  logic            hold;
  logic            wb_live;
  logic [XLEN-1:0] op1_sel;
  logic [XLEN-1:0] op2_sel;

  assign rf_rs1   = in_rs1;
  assign rf_rs2   = in_rs2;
  assign in_ready = !out_valid || out_ready;
  assign cap      = in_valid && in_ready && !flush;
  assign hold     = out_valid && !out_ready && !flush;
  // x0 writes are architecturally dropped, so they must never bypass or refresh
  assign wb_live  = wb_we && (wb_rd != 5'd0);

  // The regfile write lands on the same edge we sample, so forward it here
  always_comb begin
    // NOTE: every always_comb output gets a default first; a missed branch would infer a latch.
    op1_sel = rf_rdata1;
    op2_sel = rf_rdata2;
    if (in_rs1 == 5'd0)
      op1_sel = '0;
    else if (wb_live && (wb_rd == in_rs1))
      op1_sel = wb_wdata;
    if (in_rs2 == 5'd0)
      op2_sel = '0;
    else if (wb_live && (wb_rd == in_rs2))
      op2_sel = wb_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    if (rst)
      out_valid <= 1'b0;
    else if (flush)
      out_valid <= 1'b0;
    else if (cap)
      out_valid <= 1'b1;
    else if (out_ready)
      out_valid <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the payload is reset too, so execute never sees X before the first capture.
    if (rst) begin
      out_pc   <= '0;
      out_rs1  <= '0;
      out_rs2  <= '0;
      out_rd   <= '0;
      out_op1  <= '0;
      out_op2  <= '0;
      out_imm  <= '0;
      out_ctrl <= '0;
    end else if (cap) begin
      out_pc   <= in_pc;
      out_rs1  <= in_rs1;
      out_rs2  <= in_rs2;
      out_rd   <= in_rd;
      out_op1  <= op1_sel;
      out_op2  <= op2_sel;
      out_imm  <= in_imm;
      out_ctrl <= in_ctrl;
    end else if (hold) begin
      // A stalled instruction must not keep an operand the regfile just overwrote
      if (wb_live && (wb_rd == out_rs1))
        out_op1 <= wb_wdata;
      if (wb_live && (wb_rd == out_rs2))
        out_op2 <= wb_wdata;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: regfile model plus a scoreboard queue of
// expected execute-side instructions.
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } item_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [4:0]        in_rs1, in_rs2, in_rd;
  logic [XLEN-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        rf_rs1, rf_rs2;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_wdata;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [4:0]        out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0]   out_op1, out_op2, out_imm;
  logic [CTRL_W-1:0] out_ctrl;

  logic [XLEN-1:0] rf [32];
  item_t           q[$];
  logic            m_valid;
  logic            last_cap;
  int              n_cmp = 0;
  int              n_err = 0;
  int              n_hs  = 0;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  // Regfile model: combinational read, write on the rising edge. x0 holds
  // a non-zero value so the stage's own zero forcing is observable.
  assign rf_rdata1 = rf[rf_rs1];
  assign rf_rdata2 = rf[rf_rs2];
  always @(posedge clk)
    if (wb_we && wb_rd != 5'd0) rf[wb_rd] <= wb_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_op(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs) return wb_wdata;
    return rf[rs];
  endfunction

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [XLEN-1:0] imm,
                       input logic [CTRL_W-1:0] ctrl);
    in_valid = v; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_imm = imm; in_ctrl = ctrl;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [XLEN-1:0] d);
    wb_we = we; wb_rd = rd; wb_wdata = d;
  endtask

  // Entered just after a falling edge with inputs driven; leaves after the next one.
  task automatic tick();
    logic  cap;
    item_t it;
    #1;
    check("in_ready", in_ready, !m_valid || out_ready);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("sb_depth", q.size(), 1);
      if (q.size() > 0) begin
        check("pc", out_pc, q[0].pc);
        check("ops", {out_op1, out_op2}, {q[0].op1, q[0].op2});
        check("imm", out_imm, q[0].imm);
        check("meta", {out_rs1, out_rs2, out_rd, out_ctrl},
              {q[0].rs1, q[0].rs2, q[0].rd, q[0].ctrl});
      end
    end
    cap = in_valid && (!m_valid || out_ready) && !flush;
    if (m_valid && !out_ready && !flush && wb_we && wb_rd != 5'd0 && q.size() > 0) begin
      if (q[0].rs1 == wb_rd) q[0].op1 = wb_wdata;
      if (q[0].rs2 == wb_rd) q[0].op2 = wb_wdata;
    end
    if (m_valid && out_ready && q.size() > 0) begin
      void'(q.pop_front());
      n_hs++;
    end
    if (flush) q.delete();
    if (cap) begin
      it.pc = in_pc; it.rs1 = in_rs1; it.rs2 = in_rs2; it.rd = in_rd;
      it.op1 = exp_op(in_rs1); it.op2 = exp_op(in_rs2);
      it.imm = in_imm; it.ctrl = in_ctrl;
      q.push_back(it);
    end
    m_valid  = flush ? 1'b0 : (cap ? 1'b1 : (out_ready ? 1'b0 : m_valid));
    last_cap = cap;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int hs0;
    int sent;
    bit or_pat [10];
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(0, '0, '0, '0, '0, '0, '0);
    set_wb(0, '0, '0);
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hBAD0_0000; rf[5] = 32'h11; rf[6] = 32'h22;
    m_valid = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_valid", out_valid, 0);
    check("rst_data", {out_pc, out_op1}, 64'd0);
    check("rst_misc", {out_op2, out_imm}, 64'd0);
    check("rst_meta", {out_rs1, out_rs2, out_rd, out_ctrl}, 64'd0);
    rst = 1'b0;

    // Plain pass-through
    out_ready = 1'b1;
    drive(1, 32'h100, 5, 6, 7, 32'h4, 16'h1234);
    tick();
    drive(0, '0, '0, '0, '0, '0, '0);
    tick();

    // Write-back bypass variants, back-to-back
    drive(1, 32'h104, 5, 6, 8, 32'h8, 16'h0001); set_wb(1, 5, 32'hABCD); tick();
    drive(1, 32'h108, 5, 6, 9, 32'hC, 16'h0002); set_wb(1, 0, 32'h5555); tick();
    drive(1, 32'h10C, 0, 6, 10, 32'h10, 16'h0003); set_wb(1, 0, 32'hDEAD); tick();
    drive(1, 32'h110, 6, 5, 11, 32'h14, 16'h0004); set_wb(1, 6, 32'h77); tick();
    drive(0, '0, '0, '0, '0, '0, '0); set_wb(0, '0, '0); tick();

    // Stall refresh: held for three cycles, x6 rewritten mid-stall, x0 write ignored
    drive(1, 32'h200, 0, 6, 12, 32'h18, 16'h00AA); tick();
    out_ready = 1'b0;
    drive(1, 32'h204, 6, 6, 13, 32'h1C, 16'h00BB);
    tick();
    set_wb(1, 6, 32'h99); tick();
    set_wb(1, 0, 32'h1); tick();
    set_wb(0, '0, '0); tick();
    out_ready = 1'b1; tick();

    // Flush while stalled with a new instruction offered
    out_ready = 1'b0;
    drive(1, 32'h300, 5, 6, 14, 32'h20, 16'h00CC); flush = 1'b1; tick();
    check("flush_no_cap", last_cap, 0);
    flush = 1'b0;
    drive(1, 32'h304, 5, 6, 15, 32'h24, 16'h00DD); tick();
    check("post_flush_cap", last_cap, 1);
    drive(0, '0, '0, '0, '0, '0, '0); out_ready = 1'b1; tick();

    // Asynchronous reset mid-stall
    drive(1, 32'h400, 5, 6, 16, 32'h28, 16'h00EE); tick();
    drive(0, '0, '0, '0, '0, '0, '0); out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_op1", out_op1, 0);
    m_valid = 1'b0; q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Back-to-back stream with toggling out_ready and random write-backs
    or_pat = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 0};
    hs0  = n_hs;
    sent = 0;
    for (int c = 0; c < 60 && (sent < 8 || m_valid); c++) begin
      out_ready = or_pat[c % 10];
      if (sent < 8)
        drive(1, 32'h500 + 4 * sent, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'(sent + 1), $urandom, 16'(16'hA000 + sent));
      else
        drive(0, '0, '0, '0, '0, '0, '0);
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      tick();
      if (last_cap) sent++;
    end
    check("stream_sent", sent, 8);
    check("stream_delivered", n_hs - hs0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
